seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed driver for the 8-digit common-anode seven-segment display.
- Consumes per-digit BCD values, decimal points and enable masks from counter/datapath blocks.
- Produces the registered active-low AN and SEG buses that go straight to the top-level pins.
- Latches new frames only at frame boundaries, so a display update never tears mid-scan.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 1000, dwell rate per digit in Hz. SCAN_DIV = CLK_HZ/SCAN_HZ clock cycles per digit window.
- NUM_DIGITS, 8, number of digits scanned; legal range 1..8.
- BLANK_CYCLES, 16, anti-ghosting blank at the start of each window; must be < SCAN_DIV.

Ports:
- clk_in  input  1  system clock
- reset  input  1  reset; synchronous, active-high
- digits_in  input  4*NUM_DIGITS  BCD value for each digit; digit i is bits [4i+3:4i]; digit 0 is rightmost
- dp_in  input  NUM_DIGITS  decimal point on, per digit
- en_in  input  NUM_DIGITS  digit enable, per digit
- load  input  1  strobe: stage digits_in/dp_in/en_in for display
- load_ack  output  1  one-cycle pulse when the staged frame becomes the displayed frame
- busy  output  1  a staged frame is waiting for the next frame boundary
- AN  output  8  anode selects, active-low; AN[i] drives digit i; bits at or above NUM_DIGITS are held at 1
- SEG  output  8  cathodes, active-low; SEG[0..6] = segments a..g, SEG[7] = DP

Behaviour:
- Single clock domain: clk_in.
- Reset (synchronous, active-high):
  - AN = 8'hFF, SEG = 8'hFF, load_ack = 0, busy = 0.
  - Staged and displayed registers cleared (all enables 0, so the display is blank).
  - Digit index = 0, prescaler = 0.
  - load is ignored while reset is high.
- Prescaler counts 0..SCAN_DIV-1, then wraps.
  - On wrap, the digit index advances: 0..NUM_DIGITS-1, then back to 0.
- Frame boundary: the cycle in which the prescaler wraps while index = NUM_DIGITS-1.
- Output timing (AN/SEG registered; one cycle of latency after any prescaler/index change):
  - While prescaler < BLANK_CYCLES: AN = all 1s, SEG = 8'hFF.
  - Otherwise, if the displayed enable for the current index is 1: AN has only bit[index] = 0, and SEG = decode(value) with SEG[7] = ~dp.
  - If that enable is 0: AN stays all 1s.
- Decode table (segments lit, active-low on SEG):
  - 0: abcdef; 1: bc; 2: abdeg; 3: abcdg; 4: bcfg
  - 5: acdfg; 6: acdefg; 7: abc; 8: abcdefg; 9: abcdfg
  - Values 10..15: g only (dash), as an error indicator.
- Load handshake:
  - When load = 1, digits_in/dp_in/en_in are copied into the staging registers that cycle, and busy is set.
  - A later load before the boundary overwrites the staged frame (last wins). Only one load_ack follows.
  - At the frame boundary with busy = 1: staged → displayed, busy cleared, load_ack = 1 on the next cycle for exactly one cycle.
  - The new frame is displayed starting with the index-0 window.
  - If load = 1 in the frame-boundary cycle itself: the staged registers take the new inputs, and the displayed frame is the previously staged frame (if any). busy therefore stays 1 and the new frame waits for the following boundary.
- Reset mid-frame or mid-pending: the staged frame is discarded, no load_ack is issued, and scanning restarts at index 0.
- Arithmetic:
  - Prescaler width = $clog2(SCAN_DIV).
  - Index width = 3 bits, compared against NUM_DIGITS-1.
  - No other arithmetic.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: at capture into the displayed frame, enabled digits with value 0 located above the highest-index enabled digit holding a non-zero value get their effective enable forced to 0. Digit 0 is never suppressed. A digit with dp = 1 and everything below it are never suppressed.
- Undefined: enables are applied exactly as loaded, and zeros are always shown.

Decomposition:
- Shared package seg_pkg:
  - typedef seg_t (8-bit active-low segment vector)
  - localparams SEG_BLANK = 8'hFF and SEG_DASH
  - the 16-entry decode constant table
- Sub-module seg_glyph_decode: combinational 4-bit value + dp → seg_t. Instantiated once, on the muxed current digit.
- Prescaler, index, staging and handshake logic all live in seg_scan_driver.

Test Plan:
- Bench parameters for all scenarios: SCAN_DIV = 8 (CLK_HZ = 8000, SCAN_HZ = 1000), BLANK_CYCLES = 2, NUM_DIGITS = 8.
- Reset held 3 cycles, then released with no load -> AN = FF and SEG = FF on every cycle for 2 full frames; busy = 0, load_ack = 0.
- load one cycle with digits = 32'h76543210, en = FF, dp = 00 -> busy = 1 until the frame boundary; load_ack pulses once. Then per window: 2 blank cycles, then 6 cycles with AN = FE and SEG = C0 (digit 0); subsequent windows step AN to FD/F9 (digit 1), and so on.
- Two loads in the same frame (first value 1111_1111, then 2222_2222) -> single load_ack; all digits show 2 (SEG = A4); 1 is never displayed.
- Digit 3 value = 4'hC, en = 08, dp = 08 -> only AN = F7 windows active; SEG = 3F (dash with DP lit).
- Reset asserted while busy = 1 -> no load_ack; display returns to blank; busy = 0.
- With SEG_LEADING_ZERO_BLANK_EN defined, load digits = 32'h00000305, en = FF -> only AN = FE/FD/FB windows active (values 5, 0, 3); digits 3..7 stay dark. Without the macro, all 8 digits are lit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are active-low: bit0..6 = a..g, bit7 = DP.
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t SEG_DASH  = 8'hBF;   // g only, used for values 10..15

  localparam int MAX_DIGITS = 8;

  // Glyph table, entry = BCD value; bit7 is left high and replaced by ~dp.
  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,  // F..A
    8'h90,   // 9: abcdfg
    8'h80,   // 8: abcdefg
    8'hF8,   // 7: abc
    8'h82,   // 6: acdefg
    8'h92,   // 5: acdfg
    8'h99,   // 4: bcfg
    8'hB0,   // 3: abcdg
    8'hA4,   // 2: abdeg
    8'hF9,   // 1: bc
    8'hC0    // 0: abcdef
  };

  // One display frame, always held at full 8-digit width; unused digits stay disabled.
  typedef struct packed {
    logic [MAX_DIGITS-1:0][3:0] val;
    logic [MAX_DIGITS-1:0]      dp;
    logic [MAX_DIGITS-1:0]      en;
  } frame_t;

  // Effective enables with leading zeros dark. Walking down from the top digit,
  // zeros stay dark until a lit non-zero digit or a decimal point is met;
  // digit 0 is never touched.
  function automatic logic [MAX_DIGITS-1:0] lz_blank_en(input frame_t f);
    logic [MAX_DIGITS-1:0] en;
    logic                  hold;
    en   = f.en;
    hold = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (f.dp[i] || (f.en[i] && (f.val[i] != 4'd0))) hold = 1'b1;
      if (!hold && (f.val[i] == 4'd0)) en[i] = 1'b0;
    end
    return en;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational BCD + decimal point to active-low segment pattern.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dp,
  output seg_t       seg
);

  // table lookup for a..g, DP cathode driven separately
  always_comb begin
    seg = {~dp, SEG_TABLE[value][6:0]};
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// A prescaler sets each digit's dwell window; the first BLANK_CYCLES of every
// window are dark to stop ghosting. New frames are staged on load and only
// swapped into the displayed frame at a frame boundary so a scan never tears.
// Optional: define SEG_LEADING_ZERO_BLANK_EN to darken leading zeros at capture.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int SCAN_HZ      = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    busy,
  output logic [7:0]              AN,
  output seg_t                    SEG
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             frame_end;
  frame_t           in_frame, staged, disp;
  logic [7:0]       an_nxt;
  seg_t             seg_nxt, glyph;

  // Inputs widened to a full 8-digit frame; missing digits read as disabled.
  always_comb begin
    in_frame.val = 32'(digits_in);
    in_frame.dp  = 8'(dp_in);
    in_frame.en  = 8'(en_in);
  end

  assign frame_end = (cnt == SCAN_LAST) && (idx == IDX_LAST);

  // prescaler and digit index
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == SCAN_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // staging, frame swap and load handshake; a load in the boundary cycle
  // itself re-arms busy and waits for the following boundary
  always_ff @(posedge clk_in) begin
    if (reset) begin
      staged   <= '0;
      disp     <= '0;
      busy     <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= frame_end && busy;
      if (frame_end && busy) begin
        disp <= staged;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        disp.en <= lz_blank_en(staged);
`endif
      end
      if (load) begin
        staged <= in_frame;
        busy   <= 1'b1;
      end else if (frame_end) begin
        busy   <= 1'b0;
      end
    end
  end

  seg_glyph_decode u_glyph (
    .value (disp.val[idx]),
    .dp    (disp.dp[idx]),
    .seg   (glyph)
  );

  // next anode/cathode pattern for the current window position
  always_comb begin
    an_nxt  = 8'hFF;
    seg_nxt = SEG_BLANK;
    if ((cnt >= BLANK_LIM) && disp.en[idx]) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = glyph;
    end
  end

  // registered pin drivers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      AN  <= 8'hFF;
      SEG <= SEG_BLANK;
    end else begin
      AN  <= an_nxt;
      SEG <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: SCAN_DIV = 8, BLANK_CYCLES = 2, 8 digits.
// A timeline model (frames keyed by the boundary where they take effect) is
// compared against the pins every cycle, plus hand-computed spot checks.
module tb_seg_scan_driver;

  localparam int CLK_HZ = 8000, SCAN_HZ = 1000, NUM_DIGITS = 8, BLANK_CYCLES = 2;
  localparam int FRAME = 64;

  localparam logic [6:0] SA = 7'h01, SB = 7'h02, SC = 7'h04, SD = 7'h08,
                         SE = 7'h10, SF = 7'h20, SG = 7'h40;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        load   = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in = '0, en_in = '0;
  logic        load_ack, busy;
  logic [7:0]  AN, SEG;

  int checks = 0, errors = 0;

  seg_scan_driver #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIGITS(NUM_DIGITS), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk_in(clk_in), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .en_in(en_in),
    .load(load), .load_ack(load_ack), .busy(busy), .AN(AN), .SEG(SEG)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    int          l;      // time step at which load was sampled
    int          act;    // first time step the frame is the displayed frame
    logic [31:0] val;
    logic [7:0]  dp;
    logic [7:0]  en;
  } ld_t;

  ld_t q[$];
  int  s    = 0;   // time steps since the last reset edge
  bit  live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // lit segments (active-high) for a value
  function automatic logic [6:0] lit(input logic [3:0] v);
    case (v)
      4'd0: lit = SA|SB|SC|SD|SE|SF;
      4'd1: lit = SB|SC;
      4'd2: lit = SA|SB|SD|SE|SG;
      4'd3: lit = SA|SB|SC|SD|SG;
      4'd4: lit = SB|SC|SF|SG;
      4'd5: lit = SA|SC|SD|SF|SG;
      4'd6: lit = SA|SC|SD|SE|SF|SG;
      4'd7: lit = SA|SB|SC;
      4'd8: lit = SA|SB|SC|SD|SE|SF|SG;
      4'd9: lit = SA|SB|SC|SD|SF|SG;
      default: lit = SG;
    endcase
  endfunction

  // enables as they appear on the display
  function automatic logic [7:0] shown_en(input ld_t f);
    logic [7:0] en;
    en = f.en;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      int keep;
      keep = 0;
      for (int i = 0; i < 8; i++)
        if (f.dp[i] || (f.en[i] && f.val[i*4 +: 4] != 4'd0)) keep = i;
      for (int i = keep + 1; i < 8; i++)
        if (f.val[i*4 +: 4] == 4'd0) en[i] = 1'b0;
    end
`endif
    return en;
  endfunction

  // model timeline: record loads with the boundary they will take effect after
  always @(posedge clk_in) begin
    int  b;
    ld_t e;
    if (reset) begin
      s = 0;
      q.delete();
      live = 1'b1;
    end else begin
      if (load) begin
        b = (s / FRAME) * FRAME + FRAME - 1;
        if (b == s) b += FRAME;
        e.l = s; e.act = b + 1; e.val = digits_in; e.dp = dp_in; e.en = en_in;
        q.push_back(e);
      end
      s = s + 1;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk_in) begin
    logic [7:0] e_an, e_seg, en;
    logic       e_ack, e_busy;
    int         x, pre, dig;
    bit         have;
    ld_t        f;
    if (live) begin
      e_ack = 1'b0; e_busy = 1'b0;
      e_an = 8'hFF; e_seg = 8'hFF;
      foreach (q[k]) begin
        if (q[k].l < s && s < q[k].act) e_busy = 1'b1;
        if (q[k].act == s) e_ack = 1'b1;
      end
      if (s > 0) begin
        x = s - 1; pre = x % 8; dig = (x / 8) % 8;
        have = 1'b0; f = '0;
        foreach (q[k]) if (q[k].act <= x) begin f = q[k]; have = 1'b1; end
        if (have && pre >= BLANK_CYCLES) begin
          en = shown_en(f);
          if (en[dig]) begin
            e_an  = ~(8'h01 << dig);
            e_seg = ~{f.dp[dig], lit(f.val[dig*4 +: 4])};
          end
        end
      end
      chk("cyc_AN", AN, e_an);
      chk("cyc_SEG", SEG, e_seg);
      chk("cyc_load_ack", load_ack, e_ack);
      chk("cyc_busy", busy, e_busy);
    end
  end

  task automatic step();
    @(negedge clk_in); #1;
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
    step();
    digits_in = v; dp_in = dp; en_in = en; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    while (load_ack !== 1'b1 && n < 3 * FRAME) begin step(); n++; end
    chk(name, load_ack, 1);
  endtask

  task automatic wait_an(input string name, input logic [7:0] tgt);
    int n;
    n = 0;
    while (AN !== tgt && n < 2 * FRAME) begin step(); n++; end
    chk(name, AN, tgt);
  endtask

  task automatic wait_phase(input int m);
    int n;
    n = 0;
    while ((s % FRAME) != m && n < 2 * FRAME) begin step(); n++; end
    chk("phase_reached", s % FRAME, m);
  endtask

  initial begin
    int acks, lit_other, lit_good, seen_a4, seen_f9;
    logic [7:0] mask;

    // reset for 3 cycles, then two idle frames
    repeat (3) step();
    reset = 1'b0;
    repeat (2 * FRAME) step();
    chk("idle_AN", AN, 8'hFF);
    chk("idle_SEG", SEG, 8'hFF);
    chk("idle_busy", busy, 0);

    // single frame 76543210
    do_load(32'h7654_3210, 8'h00, 8'hFF);
    chk("load_busy", busy, 1);
    wait_ack("first_ack");
    step();
    chk("ack_one_cycle", load_ack, 0);
    chk("ack_busy_clear", busy, 0);
    wait_an("d0_AN", 8'hFE);
    chk("d0_SEG", SEG, 8'hC0);
    wait_an("d1_AN", 8'hFD);
    chk("d1_SEG", SEG, 8'hF9);
    wait_an("d2_AN", 8'hFB);
    chk("d2_SEG", SEG, 8'hA4);

    // two loads in one frame, last wins
    wait_phase(1);
    do_load(32'h1111_1111, 8'h00, 8'hFF);
    step();
    do_load(32'h2222_2222, 8'h00, 8'hFF);
    wait_ack("double_ack");
    acks = 1; seen_a4 = 0; seen_f9 = 0;
    repeat (2 * FRAME) begin
      step();
      if (load_ack) acks++;
      if (AN != 8'hFF && SEG == 8'hA4) seen_a4++;
      if (AN != 8'hFF && SEG == 8'hF9) seen_f9++;
    end
    chk("double_ack_count", acks, 1);
    chk("double_no_one", seen_f9, 0);
    chk("double_all_two", seen_a4, 2 * 8 * (8 - BLANK_CYCLES));

    // error value with DP on digit 3 only
    do_load(32'h0000_C000, 8'h08, 8'h08);
    wait_ack("dash_ack");
    lit_good = 0; lit_other = 0;
    repeat (2 * FRAME) begin
      step();
      if (AN == 8'hF7 && SEG == 8'h3F) lit_good++;
      else if (AN != 8'hFF) lit_other++;
    end
    chk("dash_cycles", lit_good, 2 * (8 - BLANK_CYCLES));
    chk("dash_others", lit_other, 0);

    // reset while a frame is pending
    wait_phase(10);
    do_load(32'h9999_9999, 8'h00, 8'hFF);
    chk("pend_busy", busy, 1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    acks = 0; lit_other = 0;
    repeat (FRAME + 8) begin
      step();
      if (load_ack) acks++;
      if (AN != 8'hFF) lit_other++;
    end
    chk("rst_no_ack", acks, 0);
    chk("rst_dark", lit_other, 0);

    // load exactly in the boundary cycle: previous staged frame shows, new one waits
    wait_phase(20);
    do_load(32'h3333_3333, 8'h00, 8'hFF);
    wait_phase(FRAME - 1);
    digits_in = 32'h4444_4444; load = 1'b1;
    step();
    load = 1'b0;
    wait_ack("bnd_ack1");
    chk("bnd_busy_kept", busy, 1);
    wait_an("bnd_d0_AN", 8'hFE);
    chk("bnd_d0_SEG", SEG, 8'hB0);
    wait_ack("bnd_ack2");
    chk("bnd_busy_done", busy, 0);
    wait_an("bnd2_d0_AN", 8'hFE);
    chk("bnd2_d0_SEG", SEG, 8'h99);

    // leading zeros
    do_load(32'h0000_0305, 8'h00, 8'hFF);
    wait_ack("lz_ack");
    mask = 8'h00;
    repeat (FRAME + 8) begin
      step();
      mask |= ~AN;
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    chk("lz_mask", mask, 8'h07);
`else
    chk("lz_mask", mask, 8'hFF);
`endif

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
